// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// branch_predict_unit : IF-stage 2-bit/BTB predictor with ID-stage resolve,
//                       mispredict redirect, training and branch statistics.
// Revision 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int ISA_WIDTH   = 32,
  parameter int INDEX_WIDTH = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ISA_WIDTH-1:0]  if_pc,
  input  logic                  if_valid,
  input  logic                  id_stall,
  input  logic                  id_flush,
  input  logic                  id_is_branch,
  input  logic                  condition_satisfied,
  input  logic [ISA_WIDTH-1:0]  id_branch_target,
  output logic                  pred_taken_if,
  output logic [ISA_WIDTH-1:0]  pred_target_if,
  output logic                  redirect_valid,
  output logic [ISA_WIDTH-1:0]  redirect_pc,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ISA_WIDTH - INDEX_WIDTH - 2;

  logic [1:0]           ctr    [ENTRIES];
  logic [ENTRIES-1:0]   tbl_valid;
  logic [TAG_WIDTH-1:0] tag    [ENTRIES];
  logic [ISA_WIDTH-1:0] target [ENTRIES];

  logic                 id_valid;
  logic [ISA_WIDTH-1:0] id_pc;
  logic                 id_pred_taken;
  logic [ISA_WIDTH-1:0] id_pred_target;

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic                   resolve;
  logic                   mispredict;
  logic                   unused_pc_bits;

  assign lk_idx  = if_pc[INDEX_WIDTH+1:2];
  assign lk_tag  = if_pc[ISA_WIDTH-1:INDEX_WIDTH+2];
  assign upd_idx = id_pc[INDEX_WIDTH+1:2];
  assign upd_tag = id_pc[ISA_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign lk_hit         = if_valid & tbl_valid[lk_idx] & (tag[lk_idx] == lk_tag);
  assign pred_taken_if  = lk_hit & ctr[lk_idx][1];
  assign pred_target_if = lk_hit ? target[lk_idx] : '0;

  assign resolve    = id_valid & id_is_branch & ~id_stall;
  assign mispredict = resolve &
                      ((condition_satisfied != id_pred_taken) |
                       (condition_satisfied & id_pred_taken &
                        (id_branch_target != id_pred_target)));

  assign redirect_valid = mispredict;
  assign redirect_pc    = !mispredict          ? '0 :
                          condition_satisfied  ? id_branch_target :
                                                 id_pc + ISA_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (redirect_valid || id_flush) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (!id_stall) begin
      id_valid       <= if_valid;
      id_pc          <= if_pc;
      id_pred_taken  <= pred_taken_if;
      id_pred_target <= pred_target_if;
    end
  end

  // A taken branch that lands on a foreign or empty entry claims it weakly taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]    <= 2'b01;
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (resolve) begin
      if (condition_satisfied) begin
        if (!tbl_valid[upd_idx] || (tag[upd_idx] != upd_tag)) begin
          ctr[upd_idx] <= 2'b10;
        end else if (ctr[upd_idx] != 2'b11) begin
          ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
        end
        tbl_valid[upd_idx] <= 1'b1;
        tag[upd_idx]       <= upd_tag;
        target[upd_idx]    <= id_branch_target;
      end else if (ctr[upd_idx] != 2'b00) begin
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve && (branch_count != '1)) begin
        branch_count <= branch_count + STAT_WIDTH'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + STAT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_predict_unit : directed stimulus with queued expectations and a
//                          decoupled monitor comparing lookup/redirect/stats.
// Revision 1.0
// ============================================================================
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_stall;
  logic        id_flush;
  logic        id_is_branch;
  logic        condition_satisfied;
  logic [31:0] id_branch_target;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predict_unit #(
    .ISA_WIDTH  (32),
    .INDEX_WIDTH(4),
    .STAT_WIDTH (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_pc               (if_pc),
    .if_valid            (if_valid),
    .id_stall            (id_stall),
    .id_flush            (id_flush),
    .id_is_branch        (id_is_branch),
    .condition_satisfied (condition_satisfied),
    .id_branch_target    (id_branch_target),
    .pred_taken_if       (pred_taken_if),
    .pred_target_if      (pred_target_if),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic        ptk;
    logic [31:0] ptgt;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        lk_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  event        sample_ev;

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s actual=0x%08h required=0x%08h", step, nm, act, exp);
    end
  endtask

  // Monitor: consumes queued expectations whenever the DUT is sampled.
  initial begin
    exp_t        e;
    logic [31:0] r;
    forever begin
      @(negedge clk or sample_ev);
      if (lk_q.size() > 0) begin
        e = lk_q.pop_front();
        chk("pred_taken_if",    e.step, {31'd0, pred_taken_if},  {31'd0, e.ptk});
        chk("pred_target_if",   e.step, pred_target_if,          e.ptgt);
        chk("redirect_valid",   e.step, {31'd0, redirect_valid}, {31'd0, e.rv});
        chk("branch_count",     e.step, branch_count,            e.bc);
        chk("mispredict_count", e.step, mispredict_count,        e.mc);
      end
      if (redirect_valid === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect actual_pc=0x%08h required=none", redirect_pc);
        end else begin
          r = rd_q.pop_front();
          chk("redirect_pc", -1, redirect_pc, r);
        end
      end
    end
  end

  task automatic apply(input logic [31:0] pc, input logic stall, input logic flush,
                       input logic isbr, input logic cond, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    if_pc               = pc;
    if_valid            = 1'b1;
    id_stall            = stall;
    id_flush            = flush;
    id_is_branch        = isbr;
    condition_satisfied = cond;
    id_branch_target    = tgt;
    step_no++;
    e.step = step_no; e.ptk = ptk; e.ptgt = ptgt; e.rv = rv;
    e.rpc  = rpc;     e.bc  = bc;  e.mc   = mc;
    lk_q.push_back(e);
    if (rv) rd_q.push_back(rpc);
  endtask

  task automatic cyc(input logic [31:0] pc, input logic stall, input logic flush,
                     input logic isbr, input logic cond, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input logic rv,
                     input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
    @(posedge clk);
    #1;
    apply(pc, stall, flush, isbr, cond, tgt, ptk, ptgt, rv, rpc, bc, mc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_pc = '0; if_valid = 1'b0; id_stall = 1'b0; id_flush = 1'b0;
    id_is_branch = 1'b0; condition_satisfied = 1'b0; id_branch_target = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //   pc          stl  fl   br   cnd  tgt        | ptk  ptgt       rv   rpc        bc  mc
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0, 0);  // cold lookup
    cyc(32'h44,  0, 0, 1, 1, 32'h80,   0, 32'h0,   1, 32'h80,  0, 0);  // first taken
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    1, 32'h80,  0, 32'h0,   1, 1);
    cyc(32'h84,  0, 0, 1, 1, 32'h80,   0, 32'h0,   0, 32'h0,   1, 1);  // correct, ctr->3
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    1, 32'h80,  0, 32'h0,   2, 1);
    cyc(32'h48,  0, 0, 1, 0, 32'h0,    0, 32'h0,   1, 32'h44,  2, 1);  // not taken, ctr->2
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    1, 32'h80,  0, 32'h0,   3, 2);
    cyc(32'h4c,  1, 0, 1, 0, 32'h0,    0, 32'h0,   0, 32'h0,   3, 2);  // stalled x3
    cyc(32'h4c,  1, 0, 1, 0, 32'h0,    0, 32'h0,   0, 32'h0,   3, 2);
    cyc(32'h4c,  1, 0, 1, 0, 32'h0,    0, 32'h0,   0, 32'h0,   3, 2);
    cyc(32'h4c,  0, 0, 1, 0, 32'h0,    0, 32'h0,   1, 32'h44,  3, 2);  // release, ctr->1
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    0, 32'h80,  0, 32'h0,   4, 3);  // hit, weak NT
    cyc(32'h80,  0, 0, 1, 1, 32'h80,   0, 32'h0,   1, 32'h80,  4, 3);  // alias miss, ctr->2
    cyc(32'h80,  0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   5, 4);
    cyc(32'h40,  0, 0, 1, 1, 32'h100,  1, 32'h80,  1, 32'h100, 5, 4);  // pre-update view
    cyc(32'h40,  0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   6, 5);  // replaced -> miss
    cyc(32'h80,  0, 1, 0, 0, 32'h0,    1, 32'h100, 0, 32'h0,   6, 5);  // flush kills entry
    cyc(32'h44,  0, 0, 1, 0, 32'h0,    0, 32'h0,   0, 32'h0,   6, 5);
    cyc(32'h80,  0, 0, 0, 0, 32'h0,    1, 32'h100, 0, 32'h0,   6, 5);
    cyc(32'h48,  0, 0, 1, 0, 32'h0,    0, 32'h0,   1, 32'h84,  6, 5);  // redirect to pc+4

    // Asynchronous reset while the redirect is still asserted.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    apply(32'h80, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
    -> sample_ev;

    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(32'h80, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
    cyc(32'h48,  0, 0, 1, 1, 32'h200,  0, 32'h0,   1, 32'h200, 0, 0);
    cyc(32'h80,  0, 0, 0, 0, 32'h0,    1, 32'h200, 0, 32'h0,   1, 1);

    repeat (2) @(negedge clk);
    #1;
    while (lk_q.size() > 0) begin
      exp_t e;
      e = lk_q.pop_front();
      checks++;
      errors++;
      $display("FAIL step%0d unsampled actual=none required=sample", e.step);
    end
    while (rd_q.size() > 0) begin
      logic [31:0] r;
      r = rd_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_redirect actual=none required_pc=0x%08h", r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
